// File: rtl/wtu_mem_arbiter.sv
// Round-robin arbiter with a bounded burst lock for the single-port WTU sample RAM.
// The winning request is registered onto the RAM port; read returns are tagged per requester.
module wtu_mem_arbiter #(
   parameter int DEPTH     = 8,
   parameter int DATA_W    = 16,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        req,
   input  logic [2:0]        we,
   input  logic [DEPTH-1:0]  addr0,
   input  logic [DEPTH-1:0]  addr1,
   input  logic [DEPTH-1:0]  addr2,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [DATA_W-1:0] wdata2,
   output logic [2:0]        gnt,
   output logic [2:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [DEPTH-1:0]  mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

   logic              owner_vld;
   logic [1:0]        owner;
   logic [1:0]        ptr;
   logic [3:0]        count;
   logic [2:0]        owner_mask;
   logic [2:0]        others;
   logic              owner_hold;
   logic [1:0]        rr_idx;
   logic [1:0]        sel;
   logic              accept;
   logic              sel_we;
   logic [DEPTH-1:0]  sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [2:0]        rd_tag;

   // The owner keeps the port until its burst budget runs out and someone else is waiting.
   always_comb begin
      owner_mask = 3'b001 << owner;
      others     = req & ~owner_mask;
      owner_hold = owner_vld && ((req & owner_mask) != 3'b000) &&
                   ((count < BURST_LIM) || (others == 3'b000));

      rr_idx = 2'd0;
      case (ptr)
         2'd1:    rr_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         2'd2:    rr_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
         default: rr_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase

      sel    = owner_hold ? owner : rr_idx;
      accept = |req;
      gnt    = accept ? (3'b001 << sel) : 3'b000;

      sel_we    = we[0];
      sel_addr  = addr0;
      sel_wdata = wdata0;
      case (sel)
         2'd1: begin
            sel_we    = we[1];
            sel_addr  = addr1;
            sel_wdata = wdata1;
         end
         2'd2: begin
            sel_we    = we[2];
            sel_addr  = addr2;
            sel_wdata = wdata2;
         end
         default: ;
      endcase
   end

   // Ownership, burst count and round-robin pointer; an idle cycle breaks any burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_vld <= 1'b0;
         owner     <= 2'd0;
         ptr       <= 2'd0;
         count     <= 4'd0;
      end else if (accept) begin
         owner_vld <= 1'b1;
         owner     <= sel;
         ptr       <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
         if (owner_vld && (sel == owner))
            count <= (count < BURST_LIM) ? count + 4'd1 : count;
         else
            count <= 4'd1;
      end else begin
         owner_vld <= 1'b0;
         count     <= 4'd0;
      end
   end

   // Command register plus a two-stage read tag that lines up with the RAM's one-cycle latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_tag    <= 3'b000;
         rvalid    <= 3'b000;
      end else begin
         mem_en <= accept;
         mem_we <= accept & sel_we;
         rd_tag <= (accept && !sel_we) ? gnt : 3'b000;
         rvalid <= rd_tag;
         if (accept) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
         end
      end
   end

   assign rdata = mem_rdata;

endmodule

// File: tb/tb_wtu_mem_arbiter.sv
// Bench for wtu_mem_arbiter: a rule-level arbitration model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wtu_mem_arbiter;

   localparam int DEPTH     = 8;
   localparam int DATA_W    = 16;
   localparam int BURST_MAX = 4;
   localparam int CYC_MAX   = 1024;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [2:0]        req = 3'b000;
   logic [2:0]        we  = 3'b000;
   logic [DEPTH-1:0]  addr0 = '0, addr1 = '0, addr2 = '0;
   logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
   logic [2:0]        gnt, rvalid;
   logic [DATA_W-1:0] rdata;
   logic              mem_en, mem_we;
   logic [DEPTH-1:0]  mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   logic [DATA_W-1:0] ram       [0:(1<<DEPTH)-1];
   bit   [DATA_W-1:0] model_mem [0:(1<<DEPTH)-1];

   int                m_owner = -1;
   int                m_count = 0;
   int                m_ptr   = 0;
   bit                e_en    = 1'b0;
   bit                e_we    = 1'b0;
   bit   [DEPTH-1:0]  e_addr  = '0;
   bit   [DATA_W-1:0] e_wdata = '0;
   bit   [2:0]        exp_rv [0:CYC_MAX-1];
   bit   [DATA_W-1:0] exp_rd [0:CYC_MAX-1];
   int                cyc = 0;

   wtu_mem_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we),
      .addr0(addr0), .addr1(addr1), .addr2(addr2),
      .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < (1 << DEPTH); i++) begin
         ram[i]       = {8'hC3, 8'(i)};
         model_mem[i] = {8'hC3, 8'(i)};
      end
   end

   // Synchronous RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_en === 1'b1) begin
         if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
         else                 mem_rdata     <= ram[mem_addr];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req_val);
      total++;
      if (act !== req_val) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req_val, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [2:0] rq, input logic [2:0] w,
                                input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                                input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
      @(posedge clk);
      #1;
      rst = r; req = rq; we = w;
      addr0 = a0; addr1 = a1; addr2 = a2;
      wdata0 = d0; wdata1 = d1; wdata2 = d2;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 16'd0, 16'd0, 16'd0);
   endtask

   // Rule-level model: pick the expected winner, compare, then advance the model one cycle.
   always @(negedge clk) begin : cmp
      int                gi;
      int                others;
      logic [2:0]        eg;
      logic [DEPTH-1:0]  a;
      logic [DATA_W-1:0] d;

      gi = -1;
      if (m_owner >= 0 && req[m_owner]) begin
         others = 0;
         for (int j = 0; j < 3; j++)
            if (j != m_owner && req[j]) others++;
         if (m_count < BURST_MAX || others == 0) gi = m_owner;
      end
      if (gi < 0)
         for (int k = 0; k < 3; k++)
            if (gi < 0 && req[(m_ptr + k) % 3]) gi = (m_ptr + k) % 3;
      eg = (gi < 0) ? 3'b000 : 3'(1 << gi);

      if (check_en) begin
         checkOutput("model_gnt", 32'(gnt), 32'(eg));
         checkOutput("model_mem_en", 32'(mem_en), 32'(e_en));
         checkOutput("model_mem_we", 32'(mem_we), 32'(e_we));
         checkOutput("model_mem_addr", 32'(mem_addr), 32'(e_addr));
         checkOutput("model_mem_wdata", 32'(mem_wdata), 32'(e_wdata));
         checkOutput("model_rvalid", 32'(rvalid), 32'(exp_rv[cyc]));
         if (exp_rv[cyc] != 3'b000)
            checkOutput("model_rdata", 32'(rdata), 32'(exp_rd[cyc]));
      end

      if (rst) begin
         m_owner = -1; m_count = 0; m_ptr = 0;
         e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
         if (cyc + 2 < CYC_MAX) begin
            exp_rv[cyc + 1] = 3'b000;
            exp_rv[cyc + 2] = 3'b000;
         end
      end else if (gi >= 0) begin
         if (gi == m_owner) m_count = (m_count < BURST_MAX) ? m_count + 1 : m_count;
         else begin
            m_owner = gi;
            m_count = 1;
         end
         m_ptr = (gi + 1) % 3;
         case (gi)
            0:       begin a = addr0; d = wdata0; end
            1:       begin a = addr1; d = wdata1; end
            default: begin a = addr2; d = wdata2; end
         endcase
         e_en = 1'b1; e_we = we[gi]; e_addr = a; e_wdata = d;
         if (we[gi]) model_mem[a] = d;
         else if (cyc + 2 < CYC_MAX) begin
            exp_rv[cyc + 2] = 3'(1 << gi);
            exp_rd[cyc + 2] = model_mem[a];
         end
      end else begin
         m_owner = -1; m_count = 0;
         e_en = 1'b0; e_we = 1'b0;
      end
      cyc++;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: actual=running required=finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      logic [2:0] burst_pat [4];
      bit found;
      burst_pat = '{3'b001, 3'b010, 3'b100, 3'b001};

      @(posedge clk);
      #1;
      check_en = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("rst_gnt", 32'(gnt), 0);
      checkOutput("rst_mem_en", 32'(mem_en), 0);
      checkOutput("rst_mem_we", 32'(mem_we), 0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 0);
      checkOutput("rst_mem_wdata", 32'(mem_wdata), 0);
      checkOutput("rst_rvalid", 32'(rvalid), 0);

      // Single loader read.
      idle();
      applyStimulus(1'b0, 3'b001, 3'b000, 8'd5, 8'd0, 8'd0, 16'd0, 16'd0, 16'd0);
      checkOutput("t1_gnt", 32'(gnt), 1);
      idle();
      checkOutput("t1_mem_en", 32'(mem_en), 1);
      checkOutput("t1_mem_addr", 32'(mem_addr), 5);
      checkOutput("t1_mem_we", 32'(mem_we), 0);
      idle();
      checkOutput("t1_rvalid", 32'(rvalid), 1);
      checkOutput("t1_rdata", 32'(rdata), 32'hC305);

      // Three-way contention with burst lock.
      applyStimulus(1'b1, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 16'd0, 16'd0, 16'd0);
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b0, 3'b111, 3'b000, 8'd10, 8'd20, 8'd30, 16'd0, 16'd0, 16'd0);
         checkOutput($sformatf("t2_gnt_%0d", k), 32'(gnt), 32'(burst_pat[k / 4]));
         if (k > 0) checkOutput($sformatf("t2_mem_en_%0d", k), 32'(mem_en), 1);
      end
      repeat (3) idle();

      // Lone streamer saturates, then the loader arrives.
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 3'b010, 3'b000, 8'd0, 8'(40 + k), 8'd0, 16'd0, 16'd0, 16'd0);
         checkOutput($sformatf("t3_gnt_%0d", k), 32'(gnt), 2);
         if (k > 0) checkOutput($sformatf("t3_mem_en_%0d", k), 32'(mem_en), 1);
      end
      found = 1'b0;
      for (int k = 0; k < BURST_MAX && !found; k++) begin
         applyStimulus(1'b0, 3'b011, 3'b000, 8'd60, 8'd61, 8'd0, 16'd0, 16'd0, 16'd0);
         if (gnt == 3'b001) found = 1'b1;
      end
      checkOutput("t3_loader_within_burst", 32'(found), 1);
      repeat (3) idle();

      // Write then read of the same address from different requesters.
      applyStimulus(1'b0, 3'b001, 3'b001, 8'd3, 8'd0, 8'd0, 16'hABCD, 16'd0, 16'd0);
      checkOutput("t4_gnt_wr", 32'(gnt), 1);
      applyStimulus(1'b0, 3'b010, 3'b000, 8'd0, 8'd3, 8'd0, 16'd0, 16'd0, 16'd0);
      checkOutput("t4_gnt_rd", 32'(gnt), 2);
      checkOutput("t4_mem_we_1", 32'(mem_we), 1);
      checkOutput("t4_mem_wdata", 32'(mem_wdata), 32'hABCD);
      idle();
      checkOutput("t4_mem_we_0", 32'(mem_we), 0);
      checkOutput("t4_mem_addr", 32'(mem_addr), 3);
      checkOutput("t4_no_rvalid_for_write", 32'(rvalid), 0);
      idle();
      checkOutput("t4_rvalid", 32'(rvalid), 2);
      checkOutput("t4_rdata", 32'(rdata), 32'hABCD);
      idle();

      // Reset with a read in flight.
      applyStimulus(1'b0, 3'b100, 3'b000, 8'd0, 8'd0, 8'd7, 16'd0, 16'd0, 16'd0);
      checkOutput("t5_gnt", 32'(gnt), 4);
      applyStimulus(1'b1, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 16'd0, 16'd0, 16'd0);
      applyStimulus(1'b0, 3'b111, 3'b000, 8'd11, 8'd12, 8'd13, 16'd0, 16'd0, 16'd0);
      checkOutput("t5_rvalid_dropped", 32'(rvalid), 0);
      checkOutput("t5_gnt_after_rst", 32'(gnt), 1);
      checkOutput("t5_mem_en_after_rst", 32'(mem_en), 0);
      idle();
      checkOutput("t5_rvalid_quiet", 32'(rvalid), 0);
      idle();
      checkOutput("t5_rvalid_new", 32'(rvalid), 1);
      checkOutput("t5_rdata_new", 32'(rdata), 32'hC30B);
      idle();

      // Drain releases mid-burst while the loader waits.
      applyStimulus(1'b0, 3'b101, 3'b000, 8'd50, 8'd0, 8'd40, 16'd0, 16'd0, 16'd0);
      checkOutput("t6_gnt_a", 32'(gnt), 4);
      applyStimulus(1'b0, 3'b101, 3'b000, 8'd50, 8'd0, 8'd41, 16'd0, 16'd0, 16'd0);
      checkOutput("t6_gnt_b", 32'(gnt), 4);
      applyStimulus(1'b0, 3'b001, 3'b000, 8'd50, 8'd0, 8'd0, 16'd0, 16'd0, 16'd0);
      checkOutput("t6_gnt_c", 32'(gnt), 1);
      checkOutput("t6_rvalid_a", 32'(rvalid), 4);
      checkOutput("t6_rdata_a", 32'(rdata), 32'hC328);
      idle();
      checkOutput("t6_rvalid_b", 32'(rvalid), 4);
      checkOutput("t6_rdata_b", 32'(rdata), 32'hC329);
      idle();
      checkOutput("t6_rvalid_c", 32'(rvalid), 1);
      checkOutput("t6_rdata_c", 32'(rdata), 32'hC332);
      repeat (2) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wtu_mem_arbiter.md
Name: wtu_mem_arbiter

Overview:
Arbitrates the single-port WTU sample RAM between three requesters: the loader (host samples in), the transform sequencer (L2R/R2L passes) and the output drain (to FIFO). It uses round-robin arbitration with a bounded burst lock, so a streaming requester keeps the port for up to BURST_MAX consecutive accesses before yielding. Memory commands are registered, and each requester receives its own read-valid strobe.

Parameters:
DEPTH, 8, RAM address width; RAM holds 2**DEPTH words.
DATA_W, 16, sample word width.
BURST_MAX, 4, maximum consecutive grants to one requester while another is pending; range 1..15.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous active-high reset.
req  input  3  per-requester access request; bit0 = loader, bit1 = transform, bit2 = drain.
we  input  3  per-requester write enable, qualified by req.
addr0/addr1/addr2  input  DEPTH each  per-requester address.
wdata0/wdata1/wdata2  input  DATA_W each  per-requester write data.
gnt  output  3  one-hot or zero; combinational; the access is accepted in a cycle where req[i] & gnt[i].
rvalid  output  3  one-hot or zero; read data valid for requester i.
rdata  output  DATA_W  shared read data; meaningful only when some rvalid bit is high.
mem_en  output  1  registered RAM enable.
mem_we  output  1  registered RAM write enable.
mem_addr  output  DEPTH  registered RAM address.
mem_wdata  output  DATA_W  registered RAM write data.
mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_en & ~mem_we.

Behaviour:
- Reset: gnt = 0, rvalid = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. Owner invalid; round-robin pointer = 0; burst count = 0. Reset mid-burst drops in-flight reads: no rvalid is produced for them.
- Arbitration, combinational from state and req:
  - If the owner is valid, req[owner] = 1 and (count < BURST_MAX or no other req is high): grant the owner.
  - Otherwise grant the first set req bit, searching from pointer, pointer+1, pointer+2 mod 3.
  - No req high: gnt = 0.
- State update on each accepted grant i:
  - If i == owner, count <= count + 1.
  - Otherwise owner <= i and count <= 1.
  - pointer <= (i + 1) mod 3.
  - Count saturates at BURST_MAX when no contender is present.
- No accept in a cycle: owner invalid, count <= 0. Pointer is unchanged.
- Command path: in the cycle after accept, mem_en = 1, mem_we = we[i], mem_addr = addr_i, mem_wdata = wdata_i. In a cycle with no accept in the previous cycle, mem_en = 0 and mem_we = 0; mem_addr and mem_wdata hold their values.
- Read return: a read accepted in cycle N gives mem_en in N+1, then rvalid[i] = 1 and rdata = mem_rdata in N+2. Writes never raise rvalid.
- Pipelining: back-to-back accepts are allowed every cycle, giving full throughput. Reads from different requesters return in acceptance order, tagged by rvalid.
- Simultaneous read and write to the same address from consecutive accepts is executed in acceptance order. Read-during-write behaviour is the RAM's; the arbiter adds no forwarding.
- req high with we high on an address ≥ 2**DEPTH is impossible by width; there is no range check.
- Releasing req mid-burst: no grant that cycle for that requester; the next grant goes to another requester or the same one restarts with count = 1.

Test Plan:
- Reset then req = 3'b001, we = 0, addr0 = 5 for 1 cycle -> gnt = 001 that cycle; mem_en = 1 with mem_addr = 5 in the next cycle; rvalid = 001 with rdata = mem_rdata two cycles after accept.
- req = 3'b111 held, BURST_MAX = 4, all reads -> gnt sequence 001 ×4, 010 ×4, 100 ×4, 001 ×4; mem_en continuously high from the cycle after the first accept.
- req = 3'b010 held alone for 10 cycles -> gnt = 010 every cycle, count saturates, and there is no gap in mem_en. Raising req[0] at cycle 10 -> loader granted within BURST_MAX cycles.
- Loader writes addr 3 = 0xABCD, then transform reads addr 3 in the next cycle -> mem_we = 1 then 0 on consecutive cycles; rvalid = 010 with rdata 0xABCD (model RAM).
- rst asserted one cycle after a read accept -> rvalid stays 0; after release, gnt resumes with pointer = 0, so requester 0 wins a 3-way tie.
- req[2] dropped after 2 grants of a burst while req[0] is pending -> gnt = 001 the next cycle, and rvalid order matches acceptance order.
